// File: rtl/wave_pkg.sv
// Package: wave_pkg
// Shared types and defaults for the waveform capture/readout path.
//   readout_state_t : readout FSM states
//   WAVE_DW         : ADC sample width, shared with the trigger capture side
//   WAVE_SCREEN_H   : default visible trace height in pixels
//   WAVE_Y_SHIFT    : default sample-to-screen right shift
package wave_pkg;

    localparam int WAVE_DW       = 12;
    localparam int WAVE_SCREEN_H = 480;
    localparam int WAVE_Y_SHIFT  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } readout_state_t;

endpackage

// File: rtl/wave_ymap.sv
// Module: wave_ymap
// Combinational mapping of a raw ADC sample to a screen row. The sample is
// scaled down by Y_SHIFT, clamped to the visible height and flipped so that
// larger samples appear higher on screen (smaller row number).
// Ports:
//   sample : in  DW  raw ADC code
//   y      : out 10  screen row, Y_OFFSET .. Y_OFFSET+SCREEN_H-1
module wave_ymap
    import wave_pkg::*;
#(
    parameter int DW       = WAVE_DW,
    parameter int Y_SHIFT  = WAVE_Y_SHIFT,
    parameter int SCREEN_H = WAVE_SCREEN_H,
    parameter int Y_OFFSET = 0
) (
    input  logic [DW-1:0] sample,
    output logic [9:0]    y
);

    // Saturate the scaled sample to the bottom visible row.
    function automatic logic [9:0] clamp_row(input logic [DW-1:0] s);
        if (32'(s) > 32'(SCREEN_H - 1)) begin
            return 10'(SCREEN_H - 1);
        end
        return 10'(s);
    endfunction

    logic [DW-1:0] shifted;

    assign shifted = sample >> Y_SHIFT;
    assign y       = 10'(Y_OFFSET) + (10'(SCREEN_H - 1) - clamp_row(shifted));

endmodule

// File: rtl/wave_readout.sv
// Module: wave_readout
// Reader side of the capture buffer. After a capture completes and the
// renderer asks for a frame, walks the sample RAM from address 0 to DEPTH-1
// and streams sample, x index and screen y over a valid/ready handshake.
// One beat takes three cycles: FETCH (issue read), WAIT (register RAM data),
// SEND (hold beat until accepted).
// Optional feature: define WAVE_READOUT_MINMAX_EN to add frame_min/frame_max
// and a one-cycle minmax_valid pulse on the last accepted beat of a frame.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   cap_done       : 1-cycle pulse, RAM holds a new frame
//   frame_req      : level, renderer ready for a new frame
//   rd_en, rd_addr : RAM read request (data returns one cycle later)
//   rd_data        : RAM read data
//   out_valid/out_ready : beat handshake
//   out_sample, out_x, out_y, out_last : beat payload
//   busy           : frame in progress
//   frame_min, frame_max, minmax_valid : (WAVE_READOUT_MINMAX_EN only)
module wave_readout
    import wave_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int AW       = $clog2(DEPTH),
    parameter int DW       = WAVE_DW,
    parameter int Y_SHIFT  = WAVE_Y_SHIFT,
    parameter int SCREEN_H = WAVE_SCREEN_H,
    parameter int Y_OFFSET = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap_done,
    input  logic          frame_req,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_sample,
    output logic [AW-1:0] out_x,
    output logic [9:0]    out_y,
    output logic          out_last,
    output logic          busy
`ifdef WAVE_READOUT_MINMAX_EN
    ,
    output logic [DW-1:0] frame_min,
    output logic [DW-1:0] frame_max,
    output logic          minmax_valid
`endif
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    readout_state_t state, state_nx;
    logic [AW-1:0]  idx;
    logic           pending;
    logic           accept;
    logic           at_end;
    logic [9:0]     y_map;

    assign accept    = (state == SEND) && out_ready;
    assign at_end    = (idx == LAST_IDX);
    assign rd_addr   = idx;
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        case (state)
            IDLE:    if (pending && frame_req) state_nx = FETCH;
            FETCH: begin
                rd_en    = 1'b1;
                state_nx = WAIT;
            end
            WAIT:    state_nx = SEND;
            SEND:    if (out_ready) state_nx = at_end ? IDLE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    // A new cap_done always wins over the clear so a capture arriving while
    // a frame starts is remembered for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nx;
            if (cap_done) begin
                pending <= 1'b1;
            end else if (state == IDLE && state_nx == FETCH) begin
                pending <= 1'b0;
            end
            if (accept) begin
                idx <= at_end ? '0 : idx + AW'(1);
            end
        end
    end

    wave_ymap #(
        .DW       (DW),
        .Y_SHIFT  (Y_SHIFT),
        .SCREEN_H (SCREEN_H),
        .Y_OFFSET (Y_OFFSET)
    ) u_ymap (
        .sample (rd_data),
        .y      (y_map)
    );

    // WAIT -> SEND boundary: RAM data and its screen row are captured together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sample <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
        end else if (state == WAIT) begin
            out_sample <= rd_data;
            out_x      <= idx;
            out_y      <= y_map;
            out_last   <= at_end;
        end
    end

`ifdef WAVE_READOUT_MINMAX_EN
    logic [DW-1:0] run_min, run_max;
    logic [DW-1:0] beat_min, beat_max;

    // Beat 0 re-seeds the trackers so a previous frame never leaks in.
    always_comb begin
        beat_min = out_sample;
        beat_max = out_sample;
        if (out_x != '0) begin
            if (run_min < out_sample) beat_min = run_min;
            if (run_max > out_sample) beat_max = run_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min      <= '0;
            run_max      <= '0;
            frame_min    <= '0;
            frame_max    <= '0;
            minmax_valid <= 1'b0;
        end else begin
            minmax_valid <= 1'b0;
            if (accept) begin
                run_min <= beat_min;
                run_max <= beat_max;
                if (out_last) begin
                    frame_min    <= beat_min;
                    frame_max    <= beat_max;
                    minmax_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wave_readout.sv
// Testbench: tb_wave_readout
// Randomized self-checking bench for wave_readout. A behavioural RAM feeds
// the DUT; every presented beat is compared with values computed directly
// from the RAM contents and the screen-mapping rules.
// Define WAVE_READOUT_MINMAX_EN to also exercise the min/max feature.
module tb_wave_readout;

    localparam int DEPTH    = 256;
    localparam int AW       = 8;
    localparam int DW       = 12;
    localparam int Y_SHIFT  = 3;
    localparam int SCREEN_H = 480;
    localparam int Y_OFFSET = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cap_done;
    logic          frame_req;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sample;
    logic [AW-1:0] out_x;
    logic [9:0]    out_y;
    logic          out_last;
    logic          busy;
`ifdef WAVE_READOUT_MINMAX_EN
    logic [DW-1:0] frame_min, frame_max;
    logic          minmax_valid;
    int            mm_pulses;
    int            mm_min, mm_max;
`endif

    logic [DW-1:0] mem [DEPTH];
    int            obs_y [DEPTH];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            last_fetch_cyc;

    always #5 clk = ~clk;

    wave_readout #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .DW       (DW),
        .Y_SHIFT  (Y_SHIFT),
        .SCREEN_H (SCREEN_H),
        .Y_OFFSET (Y_OFFSET)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_done   (cap_done),
        .frame_req  (frame_req),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .busy       (busy)
`ifdef WAVE_READOUT_MINMAX_EN
        ,
        .frame_min    (frame_min),
        .frame_max    (frame_max),
        .minmax_valid (minmax_valid)
`endif
    );

    // Synchronous-read RAM: data appears one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

`ifdef WAVE_READOUT_MINMAX_EN
    always @(negedge clk) begin
        if (minmax_valid) begin
            mm_pulses++;
            mm_min = int'(frame_min);
            mm_max = int'(frame_max);
        end
    end
`endif

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Screen row from the mapping rules: scale, clamp to visible area, flip.
    function automatic int ref_y(input int v);
        int s;
        s = v / (2 ** Y_SHIFT);
        if (s > SCREEN_H - 1) s = SCREEN_H - 1;
        return Y_OFFSET + (SCREEN_H - 1 - s);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 4095));
    endtask

    task automatic pulse_cap_done();
        @(negedge clk);
        cap_done = 1'b1;
    endtask

    // Follows one frame from the renderer's side. Checks every presented
    // beat, optional stall, optional cap_done at a beat, optional reset abort.
    task automatic check_frame(input bit rnd_ready, input int stall_x,
                               input int cdone_x, input int abort_x);
        int  x          = 0;
        int  cyc        = 0;
        int  stall_left = 0;
        bit  stalled    = 1'b0;
        bit  prev_hold  = 1'b0;
        bit  first_seen = 1'b0;
        int  last_acc   = -1;
        int  fetch_cyc  = -1;
        bit  rdy;
        while (x < DEPTH && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            cap_done = 1'b0;
            if (rd_en && fetch_cyc < 0) begin
                fetch_cyc = cyc;
                chk("first_rd_addr", rd_addr, 0);
            end
            if (prev_hold) chk("hold_valid", out_valid, 1);
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk("first_latency", cyc - fetch_cyc, 2);
                end
                if (abort_x == x) begin
                    rst_n     = 1'b0;
                    out_ready = 1'b0;
                    #1;
                    chk("abort_valid", out_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_sample", out_sample, 0);
                    last_fetch_cyc = fetch_cyc;
                    return;
                end
                chk("beat_x", out_x, x);
                chk("beat_sample", out_sample, mem[x]);
                chk("beat_y", out_y, ref_y(int'(mem[x])));
                chk("beat_last", out_last, (x == DEPTH - 1) ? 1 : 0);
                obs_y[x] = int'(out_y);
                if (stall_x == x && !stalled) begin
                    stalled    = 1'b1;
                    stall_left = 10;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    rdy = 1'b0;
                end else begin
                    rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                out_ready = rdy;
                if (rdy) begin
                    if (!rnd_ready && stall_x < 0 && last_acc >= 0)
                        chk("beat_interval", cyc - last_acc, 3);
                    if (cdone_x == x) cap_done = 1'b1;
                    last_acc  = cyc;
                    x++;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                end
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                prev_hold = 1'b0;
            end
        end
        last_fetch_cyc = fetch_cyc;
        chk("frame_done", x, DEPTH);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            cap_done = 1'b0;
            if (busy || out_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cap_done  = 1'b0;
        frame_req = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (4) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_sample", out_sample, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_last", out_last, 0);
        rst_n = 1'b1;
        expect_idle("idle_after_reset", 5);

        // Ramp frame, renderer always ready.
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 16);
        frame_req = 1'b1;
        pulse_cap_done();
        check_frame(1'b0, -1, -1, -1);
        chk("ramp_fetch_gap", last_fetch_cyc, 2);
        expect_idle("idle_after_ramp", 6);

        // Screen-mapping corners plus a 10-cycle stall at x=5.
        fill_random();
        mem[0] = 12'd0;    mem[1] = 12'd4095; mem[2] = 12'd800;
        mem[3] = 12'd3832; mem[4] = 12'd3840; mem[5] = 12'd3831;
        mem[6] = 12'd7;    mem[7] = 12'd8;
        pulse_cap_done();
        check_frame(1'b0, 5, -1, -1);
        chk("y_sample0", obs_y[0], 479);
        chk("y_sample4095", obs_y[1], 0);
        chk("y_sample800", obs_y[2], 379);
        expect_idle("idle_after_stall", 4);

        // Random back-pressure; cap_done at beat 100 queues an immediate second frame.
        fill_random();
        pulse_cap_done();
        check_frame(1'b1, -1, 100, -1);
        check_frame(1'b0, -1, -1, -1);
        chk("restart_gap", last_fetch_cyc, 2);
        expect_idle("idle_after_second", 6);

        // Capture with no frame request: must wait until frame_req rises.
        fill_random();
        frame_req = 1'b0;
        pulse_cap_done();
        expect_idle("idle_no_frame_req", 50);
        frame_req = 1'b1;
        check_frame(1'b1, -1, -1, -1);

        // Reset at beat 40 discards the frame; no restart without a new capture.
        fill_random();
        pulse_cap_done();
        check_frame(1'b0, -1, -1, 40);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_idle("idle_after_abort", 20);
        pulse_cap_done();
        check_frame(1'b1, -1, -1, -1);

`ifdef WAVE_READOUT_MINMAX_EN
        for (int i = 0; i < DEPTH; i++) mem[i] = 12'd100;
        mem[0] = 12'd7; mem[1] = 12'd4000; mem[2] = 12'd12;
        mm_pulses = 0;
        pulse_cap_done();
        check_frame(1'b1, -1, -1, -1);
        repeat (4) @(negedge clk);
        chk("mm_pulses", mm_pulses, 1);
        chk("mm_min", mm_min, 7);
        chk("mm_max", mm_max, 4000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
